// File: rtl/keypad_hex_display.sv
// Front-panel I/O: 4x4 matrix keypad scanner with debounce and a six-digit
// seven-segment display driver, all in one clock domain.
module keypad_hex_display #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_matrix,
  output logic [3:0]  lin_matrix,
  output logic [3:0]  tecla_value,
  output logic        tecla_valid,
  input  logic        enable,
  input  logic [23:0] bcd_packet,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int unsigned ScanW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StWaitRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, col_s;
  logic [1:0]       row_q, row_d;
  logic [ScanW-1:0] dwell_q, dwell_d;
  logic [DbW-1:0]   cnt_q, cnt_d;
  logic [3:0]       cap_col_q, cap_col_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic [6:0]       hex_q [6];

  // Lowest-index low column wins when several are pressed.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    if (!c[0])      col_index = 2'd0;
    else if (!c[1]) col_index = 2'd1;
    else if (!c[2]) col_index = 2'd2;
    else            col_index = 2'd3;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    unique case ({r, c})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hA;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hC;
      4'b11_00: key_code = 4'hE;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = 4'hF;
      4'b11_11: key_code = 4'hD;
    endcase
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    unique case (v)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      4'hF: hex_glyph = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 4'b1111;
      col_s     <= 4'b1111;
      state_q   <= StScan;
      row_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cap_col_q <= 4'b1111;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= col_matrix;
      col_s     <= sync1_q;
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      cap_col_q <= cap_col_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    cap_col_d = cap_col_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StScan: begin
        // Columns are only trusted on the last dwell cycle, after the
        // synchronizer has caught up with the newly driven row.
        if (dwell_q == ScanW'(SCAN_CYCLES - 1)) begin
          dwell_d = '0;
          if (col_s != 4'b1111) begin
            cap_col_d = col_s;
            cnt_d     = '0;
            state_d   = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + ScanW'(1);
        end
      end
      StDebounce: begin
        if (col_s == cap_col_q) begin
          if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            key_d   = key_code(row_q, col_index(cap_col_q));
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = StWaitRelease;
          end else begin
            cnt_d = cnt_q + DbW'(1);
          end
        end else begin
          dwell_d = '0;
          state_d = StScan;
        end
      end
      StWaitRelease: begin
        if (col_s == 4'b1111) begin
          if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            dwell_d = '0;
            row_d   = row_q + 2'd1;
            state_d = StScan;
          end else begin
            cnt_d = cnt_q + DbW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_comb begin
    lin_matrix  = ~(4'b0001 << row_q);
    tecla_value = key_q;
    tecla_valid = valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
    end else begin
      for (int i = 0; i < 6; i++) begin
        hex_q[i] <= enable ? hex_glyph(bcd_packet[4*i +: 4]) : 7'h7F;
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_keypad_hex_display.sv
// Directed bench for keypad_hex_display: a behavioural keypad pulls columns
// low only while the pressed key's row is driven.
module tb_keypad_hex_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_matrix, lin_matrix, tecla_value;
  logic        tecla_valid, enable;
  logic [23:0] bcd_packet;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [15:0] pressed;  // bit r*4+c = key at row r / column c held
  logic [3:0]  glitch;
  int          checks, errors;

  keypad_hex_display #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .col_matrix(col_matrix), .lin_matrix(lin_matrix),
    .tecla_value(tecla_value), .tecla_valid(tecla_valid), .enable(enable),
    .bcd_packet(bcd_packet), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  assign col_matrix = ~((lin_matrix[0] ? 4'h0 : pressed[3:0])   |
                        (lin_matrix[1] ? 4'h0 : pressed[7:4])   |
                        (lin_matrix[2] ? 4'h0 : pressed[11:8])  |
                        (lin_matrix[3] ? 4'h0 : pressed[15:12]) | glitch);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] hexes();
    return 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
  endfunction

  task automatic wait_strobe(input string tag, input logic [3:0] code);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      if (tecla_valid) seen = 1'b1;
    end
    chk({tag, " strobe"}, 64'(seen), 64'd1);
    chk({tag, " code"}, 64'(tecla_value), 64'(code));
    tick();
    chk({tag, " pulse width"}, 64'(tecla_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int          strobes;
    logic        found;
    logic [3:0]  exp_lin;
    int          kr[4];
    int          kc[4];
    logic [3:0]  kcode[4];

    checks = 0; errors = 0;
    reset = 1'b0; pressed = '0; glitch = '0; enable = 1'b0; bcd_packet = '0;
    kr = '{0, 2, 3, 1}; kc = '{3, 1, 0, 2}; kcode = '{4'hA, 4'h8, 4'hE, 4'h6};

    repeat (3) tick();
    chk("reset lin", 64'(lin_matrix), 64'(4'b1110));
    chk("reset valid", 64'(tecla_valid), 64'd0);
    chk("reset value", 64'(tecla_value), 64'd0);
    chk("reset hex", hexes(), 64'({6{7'h7F}}));

    // Idle scan: four clocks per row, rows 0..3 then wrap.
    reset = 1'b1;
    strobes = 0;
    chk("scan lin k0", 64'(lin_matrix), 64'(4'b1110));
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_lin = ~(4'b0001 << ((k / 4) % 4));
      chk("scan lin", 64'(lin_matrix), 64'(exp_lin));
      if (tecla_valid) strobes++;
    end
    chk("scan no strobe", 64'(strobes), 64'd0);
    chk("idle hex blank", hexes(), 64'({6{7'h7F}}));

    // Key '4' (row 1 / col 0): strobe 8 edges after row 1 becomes driven.
    pressed = 16'h0010;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (lin_matrix == 4'b1101) found = 1'b1;
    end
    chk("reach row1", 64'(found), 64'd1);
    for (int idx = 1; idx <= 12; idx++) begin
      tick();
      chk("press latency", 64'(tecla_valid), 64'(idx == 8));
    end
    chk("key4 value", 64'(tecla_value), 64'h4);
    chk("key4 lin frozen", 64'(lin_matrix), 64'(4'b1101));

    strobes = 0;
    repeat (100) begin
      tick();
      if (tecla_valid) strobes++;
    end
    chk("held no restrobe", 64'(strobes), 64'd0);
    chk("held lin frozen", 64'(lin_matrix), 64'(4'b1101));

    pressed = '0;
    for (int idx = 1; idx <= 6; idx++) begin
      tick();
      if (idx == 5) chk("release lin hold", 64'(lin_matrix), 64'(4'b1101));
      if (idx == 6) chk("release next row", 64'(lin_matrix), 64'(4'b1011));
    end

    // Single-clock glitches at every dwell phase must never be accepted.
    strobes = 0;
    for (int g = 0; g < 8; g++) begin
      glitch = 4'b0001;
      tick();
      if (tecla_valid) strobes++;
      glitch = 4'b0000;
      repeat (4) begin
        tick();
        if (tecla_valid) strobes++;
      end
    end
    repeat (8) begin
      tick();
      if (tecla_valid) strobes++;
    end
    chk("glitch no strobe", 64'(strobes), 64'd0);
    chk("glitch value held", 64'(tecla_value), 64'h4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (lin_matrix == 4'b0111) found = 1'b1;
    end
    chk("glitch scan continues", 64'(found), 64'd1);

    // '#' and 'D' together on row 3: lower column index wins.
    pressed = 16'hC000;
    wait_strobe("hash", 4'hF);
    chk("hash lin", 64'(lin_matrix), 64'(4'b0111));
    pressed = '0;
    repeat (8) tick();
    chk("hash release row0", 64'(lin_matrix), 64'(4'b1110));

    for (int n = 0; n < 4; n++) begin
      pressed = 16'(1) << (kr[n] * 4 + kc[n]);
      wait_strobe("keymap", kcode[n]);
      pressed = '0;
      repeat (8) tick();
    end

    // Display path: one clock latency, enable=0 blanks.
    enable = 1'b1; bcd_packet = 24'h543210;
    tick();
    chk("hex 543210", hexes(), 64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));
    bcd_packet = 24'hFEDCBA;
    tick();
    chk("hex FEDCBA", hexes(), 64'({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}));
    bcd_packet = 24'h987654;
    tick();
    chk("hex 987654", hexes(), 64'({7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}));
    enable = 1'b0;
    tick();
    chk("hex disabled", hexes(), 64'({6{7'h7F}}));

    // Asynchronous reset mid-operation while a key is held.
    enable = 1'b1; bcd_packet = 24'h543210;
    pressed = 16'h0001;
    wait_strobe("key1", 4'h1);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("async reset lin", 64'(lin_matrix), 64'(4'b1110));
    chk("async reset value", 64'(tecla_value), 64'd0);
    chk("async reset valid", 64'(tecla_valid), 64'd0);
    chk("async reset hex", hexes(), 64'({6{7'h7F}}));
    pressed = '0;
    tick();
    reset = 1'b1;
    chk("post reset row0", 64'(lin_matrix), 64'(4'b1110));
    repeat (4) tick();
    chk("post reset row1", 64'(lin_matrix), 64'(4'b1101));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
